// File: rtl/df_mid_lsdc_age_13_pkg.sv
// Shared helpers for the age-matrix tracker: triangular storage indexing,
// gater group sizing and a population count for the multi-pick selects.
package df_mid_lsdc_age_13_pkg;

   localparam int DEF_SIZE  = 8;
   localparam int DEF_ALLOC = 4;
   localparam int DEF_SPLIT = 4;

   function automatic int tri_bits(input int size);
      return (size * (size - 1)) / 2;
   endfunction

   // Pair (i,j) with i<j maps row-major onto the upper triangle.
   function automatic int tri_idx(input int i, input int j, input int size);
      return i * size - (i * (i + 1)) / 2 + (j - i - 1);
   endfunction

   function automatic int num_groups(input int size, input int split_en, input int split_size);
      int bits;
      bits = tri_bits(size);
      if (split_en == 0) return 1;
      return (bits + split_size - 1) / split_size;
   endfunction

   function automatic int popcnt(input logic [63:0] v);
      int n;
      n = 0;
      for (int k = 0; k < 64; k++) n += int'(v[k]);
      return n;
   endfunction

endpackage

// File: rtl/df_mid_lsdc_age_13_if.sv
// Queue-side bundle of the age tracker: alloc and pick requests in,
// one-hot selects and the full age matrix out.
interface df_mid_lsdc_age_13_if #(
   parameter int SIZE  = 8,
   parameter int ALLOC = 4,
   parameter int PICK  = 1
);
   logic [SIZE-1:0]             Valid;
   logic [ALLOC-1:0][SIZE-1:0]  AllocIdx;
   logic [ALLOC-1:0]            AllocVal;
   logic [PICK-1:0][SIZE-1:0]   Pickable;
   logic [PICK-1:0][SIZE-1:0]   Oldest;
   logic [PICK-1:0][SIZE-1:0]   Youngest;
   logic [SIZE-1:0][SIZE-1:0]   Age;

   modport master (
      output Valid, AllocIdx, AllocVal, Pickable,
      input  Oldest, Youngest, Age
   );

   modport slave (
      input  Valid, AllocIdx, AllocVal, Pickable,
      output Oldest, Youngest, Age
   );
endinterface

// File: rtl/df_mid_lsdc_age_matrixcvt.sv
// Folds a full next-age matrix into triangular storage bits and unfolds the
// stored triangle back into the antisymmetric 2-D age matrix.
module df_mid_lsdc_age_matrixcvt
   import df_mid_lsdc_age_13_pkg::*;
#(
   parameter int SIZE = DEF_SIZE,
   parameter int TRI  = tri_bits(SIZE)
) (
   input  logic [SIZE-1:0][SIZE-1:0] nxt_age,
   output logic [TRI-1:0]            nxt_tri,
   input  logic [TRI-1:0]            tri_q,
   output logic [SIZE-1:0][SIZE-1:0] age,
   output logic                      malformed
);

   // malformed flags a next-age matrix that is not antisymmetric with a zero diagonal
   always_comb begin
      nxt_tri   = '0;
      age       = '0;
      malformed = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         for (int j = 0; j < SIZE; j++) begin
            if (i < j) begin
               nxt_tri[tri_idx(i, j, SIZE)] = nxt_age[i][j];
               malformed = malformed | (nxt_age[i][j] == nxt_age[j][i]);
               age[i][j] = tri_q[tri_idx(i, j, SIZE)];
               age[j][i] = ~tri_q[tri_idx(i, j, SIZE)];
            end else if (i == j) begin
               malformed = malformed | nxt_age[i][i];
            end
         end
      end
   end

endmodule

// File: rtl/df_mid_lsdc_age_13.sv
// Age-matrix tracker: records allocation order of every entry pair in gated
// triangular flops and picks the oldest/youngest valid, pickable entry.
module df_mid_lsdc_age_13
   import df_mid_lsdc_age_13_pkg::*;
#(
   parameter int SIZE              = DEF_SIZE,
   parameter int ALLOC             = DEF_ALLOC,
   parameter int PICK              = 1,
   parameter int MULTIPICK         = 0,
   parameter int ALLOCAGE          = 1,
   parameter int ALLOCMULTIHOT     = 0,
   parameter int GATER_SPLIT_EN    = 1,
   parameter int GATER_SPLIT_SIZE  = DEF_SPLIT,
   parameter int NO_INVALID_CHECK  = 0,
   parameter int ACCURATE_GATER_EN = 1,
   parameter int CHK_MODE          = 0
) (
   input logic                  KCLK_AR,
   input logic                  Reset,
   input logic                  SSE,
   df_mid_lsdc_age_13_if.slave  bus
);

   localparam int TRI = tri_bits(SIZE);
   localparam int GS  = (GATER_SPLIT_EN != 0) ? GATER_SPLIT_SIZE : TRI;
   localparam int NG  = num_groups(SIZE, GATER_SPLIT_EN, GATER_SPLIT_SIZE);
   localparam int PW  = (ALLOC > 1) ? $clog2(ALLOC) : 1;

   logic [SIZE-1:0]            alloc;
   logic [PW-1:0]              pidx [SIZE];
   logic [SIZE-1:0][SIZE-1:0]  nxt_age;
   logic [SIZE-1:0][SIZE-1:0]  age;
   logic [TRI-1:0]             nxt_tri;
   logic [TRI-1:0]             tri_q;
   logic [TRI-1:0]             touched;
   logic [NG-1:0]              grp_hit;
   logic [NG-1:0]              grp_en;
   logic                       malformed;
   logic [PICK-1:0][SIZE-1:0]  oldest;
   logic [PICK-1:0][SIZE-1:0]  youngest;
   logic [SIZE-1:0]            cand;
   logic [SIZE-1:0]            older_c;
   logic [SIZE-1:0]            younger_c;

   // Alloc decode: pidx holds the port that orders each allocated entry
   always_comb begin
      alloc = '0;
      for (int k = 0; k < SIZE; k++) pidx[k] = '0;
      for (int a = 0; a < ALLOC; a++) begin
         for (int k = 0; k < SIZE; k++) begin
            if (bus.AllocVal[a] && bus.AllocIdx[a][k]) begin
               if (!alloc[k] || ALLOCAGE != 0) pidx[k] = PW'(a);
               alloc[k] = 1'b1;
            end
         end
      end
   end

   // Next age: allocated entries drop below all others; ties between
   // same-cycle allocs go to the lower port, then the lower entry index.
   always_comb begin
      logic v;
      v       = 1'b0;
      nxt_age = '0;
      touched = '0;
      for (int i = 0; i < SIZE; i++) begin
         for (int j = i + 1; j < SIZE; j++) begin
            if (alloc[i] && alloc[j]) v = (pidx[i] <= pidx[j]);
            else if (alloc[i])        v = 1'b0;
            else if (alloc[j])        v = 1'b1;
            else                      v = age[i][j];
            nxt_age[i][j] = v;
            nxt_age[j][i] = ~v;
            touched[tri_idx(i, j, SIZE)] = alloc[i] | alloc[j];
         end
      end
   end

   df_mid_lsdc_age_matrixcvt #(
      .SIZE (SIZE),
      .TRI  (TRI)
   ) u_cvt (
      .nxt_age   (nxt_age),
      .nxt_tri   (nxt_tri),
      .tri_q     (tri_q),
      .age       (age),
      .malformed (malformed)
   );

   always_comb begin
      grp_hit = '0;
      for (int b = 0; b < TRI; b++) grp_hit[b / GS] = grp_hit[b / GS] | touched[b];
      for (int g = 0; g < NG; g++) begin
         grp_en[g] = Reset | SSE |
                     ((ACCURATE_GATER_EN != 0) ? grp_hit[g] : (|bus.AllocVal));
      end
   end

   // Storage: each group only loads when enabled; reset wins over alloc
   always_ff @(posedge KCLK_AR) begin
      for (int b = 0; b < TRI; b++) begin
         if (grp_en[b / GS]) tri_q[b] <= Reset ? 1'b0 : nxt_tri[b];
      end
      if (CHK_MODE != 0 && !Reset) begin
         assert (!$isunknown(KCLK_AR));
         assert (!malformed);
         for (int a = 0; a < ALLOC; a++) begin
            if (ALLOCMULTIHOT == 0 && bus.AllocVal[a]) assert ($onehot(bus.AllocIdx[a]));
            for (int b2 = a + 1; b2 < ALLOC; b2++) begin
               assert (!(bus.AllocVal[a] && bus.AllocVal[b2] &&
                         (|(bus.AllocIdx[a] & bus.AllocIdx[b2]))));
            end
         end
      end
   end

   // Pick: an entry is oldest when no other candidate is older than it
   always_comb begin
      oldest    = '0;
      youngest  = '0;
      cand      = '0;
      older_c   = '0;
      younger_c = '0;
      for (int p = 0; p < PICK; p++) begin
         cand = bus.Pickable[(MULTIPICK != 0) ? 0 : p] &
                (bus.Valid | {SIZE{NO_INVALID_CHECK != 0}});
         for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
               older_c[j]   = cand[j] & age[j][i];
               younger_c[j] = cand[j] & age[i][j];
            end
            if (MULTIPICK != 0) begin
               oldest[p][i]   = cand[i] & (popcnt(64'(older_c)) == p);
               youngest[p][i] = cand[i] & (popcnt(64'(younger_c)) == p);
            end else begin
               oldest[p][i]   = cand[i] & ~(|older_c);
               youngest[p][i] = cand[i] & ~(|younger_c);
            end
         end
      end
   end

   assign bus.Oldest   = oldest;
   assign bus.Youngest = youngest;
   assign bus.Age      = age;

endmodule

// File: tb/tb_df_mid_lsdc_age_13.sv
// Directed bench for the age-matrix tracker: a vector table for pick results
// plus hand sequences for full-matrix, scan-enable and reset cases.
module tb_df_mid_lsdc_age_13;

   logic clk = 1'b0;
   logic rst;
   logic sse;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   df_mid_lsdc_age_13_if #(.SIZE(8), .ALLOC(4), .PICK(1)) bus ();

   df_mid_lsdc_age_13 dut (
      .KCLK_AR (clk),
      .Reset   (rst),
      .SSE     (sse),
      .bus     (bus.slave)
   );

   typedef struct {
      logic       rst;
      logic [3:0] aval;
      logic [7:0] i0, i1, i2, i3;
      logic [7:0] valid, pick;
      logic [7:0] exp_old, exp_yng;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // ord lists entries oldest first
   function automatic logic [63:0] age_of(input int ord[8]);
      logic [7:0][7:0] r;
      int rank[8];
      for (int k = 0; k < 8; k++) rank[ord[k]] = k;
      r = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            r[i][j] = (i != j) && (rank[i] < rank[j]);
      return r;
   endfunction

   function automatic logic [63:0] reset_age();
      logic [7:0][7:0] r;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            r[i][j] = (i > j);
      return r;
   endfunction

   task automatic cycle(input logic r, input logic [3:0] av,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3);
      rst = r;
      bus.AllocVal = av;
      bus.AllocIdx[0] = a0; bus.AllocIdx[1] = a1;
      bus.AllocIdx[2] = a2; bus.AllocIdx[3] = a3;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.AllocVal = '0;
      bus.AllocIdx = '0;
   endtask

   initial begin
      int ord[8];
      rst = 1'b1; sse = 1'b0;
      bus.Valid = '0; bus.Pickable = '1; bus.AllocVal = '0; bus.AllocIdx = '0;

      vt[0]  = '{1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
      vt[1]  = '{1'b0, 4'b0001, 8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 8'hFF, 8'h08, 8'h08};
      vt[2]  = '{1'b0, 4'b0001, 8'h20, 8'h00, 8'h00, 8'h00, 8'h28, 8'hFF, 8'h08, 8'h20};
      vt[3]  = '{1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
      vt[4]  = '{1'b0, 4'b0011, 8'h02, 8'h40, 8'h00, 8'h00, 8'h42, 8'hFF, 8'h02, 8'h40};
      vt[5]  = '{1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h42, 8'h40, 8'h40, 8'h40};
      vt[6]  = '{1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h42, 8'h00, 8'h00, 8'h00};
      vt[7]  = '{1'b0, 4'b0001, 8'h02, 8'h00, 8'h00, 8'h00, 8'h42, 8'hFF, 8'h40, 8'h02};
      vt[8]  = '{1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
      vt[9]  = '{1'b0, 4'b1111, 8'h01, 8'h80, 8'h04, 8'h10, 8'hFF, 8'hFF, 8'h20, 8'h10};
      vt[10] = '{1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h4A, 8'hFF, 8'h08, 8'h02};
      vt[11] = '{1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h85, 8'hFF, 8'h01, 8'h04};

      // Reset state
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("reset_oldest", 64'(bus.Oldest), 64'h0);
      chk("reset_youngest", 64'(bus.Youngest), 64'h0);
      chk("reset_age", bus.Age, reset_age());

      for (int v = 0; v < 12; v++) begin
         cycle(vt[v].rst, vt[v].aval, vt[v].i0, vt[v].i1, vt[v].i2, vt[v].i3);
         bus.Valid    = vt[v].valid;
         bus.Pickable = vt[v].pick;
         #1;
         chk($sformatf("vec%0d_oldest", v), 64'(bus.Oldest), 64'(vt[v].exp_old));
         chk($sformatf("vec%0d_youngest", v), 64'(bus.Youngest), 64'(vt[v].exp_yng));
      end

      // Full matrix after two single allocs, then held under scan enable
      bus.Pickable = 8'hFF;
      cycle(1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
      cycle(1'b0, 4'b0001, 8'h08, 8'h00, 8'h00, 8'h00);
      cycle(1'b0, 4'b0001, 8'h20, 8'h00, 8'h00, 8'h00);
      ord = '{7, 6, 4, 2, 1, 0, 3, 5};
      chk("age_3_5", bus.Age, age_of(ord));
      sse = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk($sformatf("sse_hold%0d", c), bus.Age, age_of(ord));
      end
      sse = 1'b0;
      bus.Valid = 8'h28;
      #1;
      chk("sse_oldest", 64'(bus.Oldest), 64'h08);

      // Reset mid-sequence beats a same-cycle alloc
      cycle(1'b0, 4'b0001, 8'h01, 8'h00, 8'h00, 8'h00);
      ord = '{7, 6, 4, 2, 1, 3, 5, 0};
      chk("age_alloc0", bus.Age, age_of(ord));
      cycle(1'b1, 4'b0001, 8'h04, 8'h00, 8'h00, 8'h00);
      chk("mid_reset_age", bus.Age, reset_age());

      // Oldest entry re-aged, then a four-port alloc in one cycle
      cycle(1'b0, 4'b0001, 8'h80, 8'h00, 8'h00, 8'h00);
      ord = '{6, 5, 4, 3, 2, 1, 0, 7};
      chk("age_alloc7", bus.Age, age_of(ord));
      cycle(1'b0, 4'b1111, 8'h08, 8'h01, 8'h40, 8'h20);
      ord = '{4, 2, 1, 7, 3, 0, 6, 5};
      chk("age_4port", bus.Age, age_of(ord));
      bus.Valid = 8'hFF;
      #1;
      chk("4port_oldest", 64'(bus.Oldest), 64'h10);
      chk("4port_youngest", 64'(bus.Youngest), 64'h20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
